// File: rtl/result_display.sv
// result_display: captures a^2+b results, keeps current/previous, drives LEDs and two hex digits.
module result_display #(
  parameter int STRETCH_CYCLES = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataResult,
  input  logic       ResultValid,
  input  logic       ShowPrev,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic       NewFlag,
  output logic [3:0] ResultCount
);
  localparam int CW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic {EMPTY, SHOW} state_t;
  state_t          r_state, w_state_nxt;
  logic            r_valid_d, r_cur_ok, r_prev_ok, r_new, r_sat;
  logic [7:0]      r_cur, r_prev, r_led;
  logic [6:0]      r_hex0, r_hex1;
  logic [3:0]      r_count;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_cap, w_sel_ok, w_blank;
  logic [7:0]      w_sel;
  function automatic logic [6:0] seg(input logic [3:0] nib);
    return SEG_ACTIVE_LOW ? ~SEG_LUT[nib] : SEG_LUT[nib];
  endfunction
  always_comb begin
    w_cap       = ResultValid & ~r_valid_d;
    w_state_nxt = w_cap ? SHOW : r_state;
    w_cnt_nxt   = w_cap ? CW'(STRETCH_CYCLES) : (r_cnt != '0 ? r_cnt - 1'b1 : r_cnt);
    w_sel       = ShowPrev ? r_prev : r_cur;
    w_sel_ok    = ShowPrev ? r_prev_ok : r_cur_ok;
    w_blank     = (r_state == EMPTY) | ~w_sel_ok;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= EMPTY;
      r_valid_d <= 1'b0;
      r_cur     <= '0;
      r_prev    <= '0;
      r_cur_ok  <= 1'b0;
      r_prev_ok <= 1'b0;
      r_cnt     <= '0;
      r_new     <= 1'b0;
      r_count   <= '0;
      r_led     <= '0;
      r_sat     <= 1'b0;
      r_hex0    <= SEG_OFF;
      r_hex1    <= SEG_OFF;
    end else begin
      r_state   <= w_state_nxt;
      r_valid_d <= ResultValid;
      r_cnt     <= w_cnt_nxt;
      // NewFlag tracks the post-edge counter so it rises on the capture edge itself
      r_new     <= w_cnt_nxt != '0;
      if (w_cap) begin
        r_cur     <= DataResult;
        r_prev    <= r_cur;
        r_prev_ok <= r_cur_ok;
        r_cur_ok  <= 1'b1;
        r_count   <= r_count == 4'd15 ? r_count : r_count + 4'd1;
      end
      r_sat  <= r_count == 4'd15;
      r_led  <= w_blank ? 8'h00 : w_sel;
      r_hex0 <= w_blank ? SEG_OFF : seg(w_sel[3:0]);
      r_hex1 <= w_blank ? SEG_OFF : seg(w_sel[7:4]);
    end
  end
  assign LEDR        = {r_sat, r_new, r_led};
  assign HEX0        = r_hex0;
  assign HEX1        = r_hex1;
  assign NewFlag     = r_new;
  assign ResultCount = r_count;
endmodule

// File: tb/tb_result_display.sv
// tb_result_display: directed scenarios plus random traffic against a capture-history model.
module tb_result_display;
  localparam int S = 4;
  logic       clk = 1'b0;
  logic       rst, valid, show;
  logic [7:0] data;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1;
  logic       NewFlag;
  logic [3:0] ResultCount;
  int n_tests = 0;
  int n_fail = 0;
  result_display #(.STRETCH_CYCLES(S), .SEG_ACTIVE_LOW(1'b1)) dut (
    .Clock(clk), .Reset(rst), .DataResult(data), .ResultValid(valid), .ShowPrev(show),
    .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .NewFlag(NewFlag), .ResultCount(ResultCount)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic [6:0] glyph [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100, 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };
  logic [7:0] hist [$];
  logic       prev_v, armed = 1'b0;
  int         since;
  logic [9:0] e_led;
  logic [6:0] e_hex0, e_hex1;
  logic       e_nf;
  logic [3:0] e_cnt;
  always @(posedge clk) begin
    int n;
    logic ok;
    logic [7:0] v;
    if (rst) begin
      hist.delete();
      prev_v = 1'b0;
      since  = 1000;
      e_led  = '0;
      e_hex0 = 7'h7F;
      e_hex1 = 7'h7F;
      e_nf   = 1'b0;
      e_cnt  = '0;
      armed  = 1'b1;
    end else if (armed) begin
      n  = hist.size();
      ok = show ? n >= 2 : n >= 1;
      v  = ok ? (show ? hist[n-2] : hist[n-1]) : 8'h00;
      e_led[7:0] = v;
      e_led[9]   = n >= 15;
      e_hex0 = ok ? ~glyph[v[3:0]] : 7'h7F;
      e_hex1 = ok ? ~glyph[v[7:4]] : 7'h7F;
      if (valid && !prev_v) begin
        hist.push_back(data);
        since = 0;
      end else if (since < 1000) since++;
      prev_v   = valid;
      e_nf     = since < S;
      e_led[8] = e_nf;
      e_cnt    = hist.size() >= 15 ? 4'd15 : 4'(hist.size());
    end
  end
  always @(negedge clk) if (armed) begin
    chk("ledr", 32'(LEDR), 32'(e_led));
    chk("hex0", 32'(HEX0), 32'(e_hex0));
    chk("hex1", 32'(HEX1), 32'(e_hex1));
    chk("newflag", 32'(NewFlag), 32'(e_nf));
    chk("count", 32'(ResultCount), 32'(e_cnt));
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic [7:0] d);
    data = d;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    tick(1);
  endtask
  initial begin
    int hi;
    logic [7:0] last;
    rst = 1'b1; valid = 1'b0; show = 1'b0; data = '0;
    tick(2);
    chk("rst_ledr", 32'(LEDR), 0);
    chk("rst_hex0", 32'(HEX0), 32'h7F);
    chk("rst_hex1", 32'(HEX1), 32'h7F);
    chk("rst_nf", 32'(NewFlag), 0);
    chk("rst_cnt", 32'(ResultCount), 0);
    rst = 1'b0; show = 1'b1;
    tick(1);
    chk("empty_prev_hex0", 32'(HEX0), 32'h7F);
    show = 1'b0; data = 8'h3A; valid = 1'b1;
    tick(1);
    valid = 1'b0; hi = 0;
    for (int i = 0; i < 8; i++) begin
      hi += int'(NewFlag);
      if (i == 1) begin
        chk("t2_hex1", 32'(HEX1), 32'h30);
        chk("t2_hex0", 32'(HEX0), 32'h08);
        chk("t2_led", 32'(LEDR[7:0]), 32'h3A);
        chk("t2_cnt", 32'(ResultCount), 1);
      end
      tick(1);
    end
    chk("t2_stretch", 32'(hi), S);
    data = 8'h05; valid = 1'b1;
    tick(10);
    valid = 1'b0;
    tick(2);
    chk("t3_cnt", 32'(ResultCount), 2);
    show = 1'b1; tick(1);
    chk("t3_prev", 32'(LEDR[7:0]), 32'h3A);
    show = 1'b0; tick(1);
    chk("t3_cur", 32'(LEDR[7:0]), 32'h05);
    tick(6);
    data = 8'h11; valid = 1'b1; tick(1);
    valid = 1'b0; tick(1);
    data = 8'h22; valid = 1'b1; tick(1);
    valid = 1'b0; hi = 0;
    for (int i = 0; i < 8; i++) begin
      hi += int'(NewFlag);
      tick(1);
    end
    chk("t4_stretch", 32'(hi), S);
    for (int i = 0; i < 17; i++) begin
      last = 8'($urandom);
      pulse(last);
    end
    tick(1);
    chk("t5_cnt", 32'(ResultCount), 15);
    chk("t5_sat", 32'(LEDR[9]), 1);
    chk("t5_val", 32'(LEDR[7:0]), 32'(last));
    data = 8'h77; valid = 1'b1; tick(1);
    valid = 1'b0; rst = 1'b1; tick(1);
    chk("t6_led", 32'(LEDR), 0);
    chk("t6_nf", 32'(NewFlag), 0);
    chk("t6_cnt", 32'(ResultCount), 0);
    chk("t6_hex", 32'({HEX1, HEX0}), 32'h3FFF);
    rst = 1'b0;
    pulse(8'hF0);
    chk("t6_hex1", 32'(HEX1), 32'h0E);
    chk("t6_hex0", 32'(HEX0), 32'h40);
    chk("t6_cnt1", 32'(ResultCount), 1);
    rst = 1'b1; valid = 1'b1; data = 8'h99; tick(1);
    rst = 1'b0; tick(3);
    valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst   = $urandom_range(0, 49) == 0;
      valid = $urandom_range(0, 2) == 0;
      show  = $urandom_range(0, 3) == 0;
      data  = 8'($urandom);
      tick(1);
    end
    rst = 1'b0; valid = 1'b0;
    tick(S + 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
